// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: decodes opcode into an extension mode, extends the raw
// immediate to DATA_W and queues it in a 2-entry skid buffer behind a valid/ready handshake.
`timescale 1ns/1ps

module imm_extend_pipe #(
    parameter int          DATA_W    = 32,
    parameter int          IMM_W     = 16,
    parameter int          SHAMT_W   = 5,
    parameter int          SHAMT_LSB = 11,
    parameter logic [5:0]  OPC_SHIFT = 6'b000010,
    parameter logic [5:0]  OPC_LOGIC = 6'b000100,
    parameter logic [5:0]  OPC_UPPER = 6'b000011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [IMM_W-1:0]  in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        out_mode
);

    // state   | meaning
    // S_EMPTY | no entry buffered, out_valid low
    // S_ONE   | head holds the only entry
    // S_FULL  | head and tail both hold entries, in_ready low
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SEXT  = 2'd0;
    localparam logic [1:0] MODE_SHAMT = 2'd1;
    localparam logic [1:0] MODE_ZEXT  = 2'd2;
    localparam logic [1:0] MODE_UPPER = 2'd3;

    localparam int PAD_W = DATA_W - IMM_W;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] head_imm;
    logic [1:0]        head_mode;
    logic [DATA_W-1:0] tail_imm;
    logic [1:0]        tail_mode;

    logic              push;
    logic              pop;
    logic              head_we;
    logic              head_from_tail;
    logic              tail_we;

    logic [DATA_W-1:0] sext_val;
    logic [DATA_W-1:0] zext_val;
    logic [DATA_W-1:0] upper_val;
    logic [DATA_W-1:0] shamt_val;
    logic [DATA_W-1:0] ext_imm;
    logic [1:0]        ext_mode;

    // Equal widths leave nothing to pad; the padded forms would need zero-width replication.
    generate
        if (PAD_W == 0) begin : g_no_pad
            assign sext_val  = in_imm;
            assign zext_val  = in_imm;
            assign upper_val = in_imm;
        end else begin : g_pad
            assign sext_val  = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
            assign zext_val  = {{PAD_W{1'b0}}, in_imm};
            assign upper_val = {in_imm, {PAD_W{1'b0}}};
        end
    endgenerate

    assign shamt_val = DATA_W'(in_imm[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]);

    always_comb begin
        ext_imm  = sext_val;
        ext_mode = MODE_SEXT;
        if (in_opcode == OPC_SHIFT) begin
            ext_imm  = shamt_val;
            ext_mode = MODE_SHAMT;
        end else if (in_opcode == OPC_UPPER) begin
            ext_imm  = upper_val;
            ext_mode = MODE_UPPER;
        end else if (in_opcode == OPC_LOGIC) begin
            ext_imm  = zext_val;
            ext_mode = MODE_ZEXT;
        end
    end

    // in_ready only looks at registered state, never at out_ready.
    assign in_ready  = (state != S_FULL) & ~rst;
    assign out_valid = (state != S_EMPTY);
    assign out_imm   = head_imm;
    assign out_mode  = head_mode;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        head_we        = 1'b0;
        head_from_tail = 1'b0;
        tail_we        = 1'b0;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    head_we   = 1'b1;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_we = 1'b1;
                end else if (push) begin
                    tail_we   = 1'b1;
                    state_nxt = S_FULL;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    head_from_tail = 1'b1;
                    state_nxt      = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            head_imm  <= '0;
            head_mode <= MODE_SEXT;
            tail_imm  <= '0;
            tail_mode <= MODE_SEXT;
        end else begin
            state <= state_nxt;
            if (head_we) begin
                head_imm  <= ext_imm;
                head_mode <= ext_mode;
            end else if (head_from_tail) begin
                head_imm  <= tail_imm;
                head_mode <= tail_mode;
            end
            if (tail_we) begin
                tail_imm  <= ext_imm;
                tail_mode <= ext_mode;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default build plus a 64/12-bit build sharing clock and reset.
`timescale 1ns/1ps

module tb_imm_extend_pipe;

    typedef struct {
        logic [5:0]  opc;
        logic [15:0] imm;
        logic [63:0] exp_imm;
        logic [1:0]  exp_mode;
    } vec_t;

    logic        clk;
    logic        rst;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [5:0]  a_in_opcode;
    logic [15:0] a_in_imm;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [31:0] a_out_imm;
    logic [1:0]  a_out_mode;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [5:0]  b_in_opcode;
    logic [11:0] b_in_imm;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_imm;
    logic [1:0]  b_out_mode;

    int n_cmp;
    int n_err;

    vec_t tbl_a[7];
    vec_t tbl_b[6];

    imm_extend_pipe dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_opcode (a_in_opcode),
        .in_imm    (a_in_imm),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_imm   (a_out_imm),
        .out_mode  (a_out_mode)
    );

    imm_extend_pipe #(
        .DATA_W    (64),
        .IMM_W     (12),
        .SHAMT_W   (6),
        .SHAMT_LSB (6)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_opcode (b_in_opcode),
        .in_imm    (b_in_imm),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_imm   (b_out_imm),
        .out_mode  (b_out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [5:0] opc, input logic [15:0] imm);
        a_in_valid  = 1'b1;
        a_in_opcode = opc;
        a_in_imm    = imm;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        tbl_a[0] = '{6'h08, 16'h8001, 64'hFFFF8001, 2'd0};
        tbl_a[1] = '{6'h00, 16'h7FFF, 64'h00007FFF, 2'd0};
        tbl_a[2] = '{6'h02, 16'hF8C0, 64'h0000001F, 2'd1};
        tbl_a[3] = '{6'h02, 16'h07FF, 64'h00000000, 2'd1};
        tbl_a[4] = '{6'h04, 16'h8001, 64'h00008001, 2'd2};
        tbl_a[5] = '{6'h03, 16'h1234, 64'h12340000, 2'd3};
        tbl_a[6] = '{6'h3F, 16'hFFFF, 64'hFFFFFFFF, 2'd0};

        tbl_b[0] = '{6'h08, 16'h0801, 64'hFFFFFFFFFFFFF801, 2'd0};
        tbl_b[1] = '{6'h02, 16'h0FC0, 64'h000000000000003F, 2'd1};
        tbl_b[2] = '{6'h02, 16'h003F, 64'h0000000000000000, 2'd1};
        tbl_b[3] = '{6'h04, 16'h0801, 64'h0000000000000801, 2'd2};
        tbl_b[4] = '{6'h03, 16'h0234, 64'h2340000000000000, 2'd3};
        tbl_b[5] = '{6'h08, 16'h07FF, 64'h00000000000007FF, 2'd0};

        rst         = 1'b1;
        a_in_valid  = 1'b1;
        a_in_opcode = 6'h08;
        a_in_imm    = 16'hAAAA;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_opcode = 6'h00;
        b_in_imm    = 12'h000;
        b_out_ready = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_imm", 64'(a_out_imm), 64'd0);
        check("rst_a_out_mode", 64'(a_out_mode), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_out_imm", b_out_imm, 64'd0);
        a_in_valid = 1'b0;
        rst        = 1'b0;
        #1;
        check("post_rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

        // decode table, default build; each push overlaps the previous pop
        a_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push_a(tbl_a[i].opc, tbl_a[i].imm);
            tick();
            a_in_valid = 1'b0;
            check($sformatf("a_vec%0d_valid", i), 64'(a_out_valid), 64'd1);
            check($sformatf("a_vec%0d_imm", i), 64'(a_out_imm), tbl_a[i].exp_imm);
            check($sformatf("a_vec%0d_mode", i), 64'(a_out_mode), 64'(tbl_a[i].exp_mode));
        end
        tick();
        check("a_table_drain", 64'(a_out_valid), 64'd0);

        // decode table, 64/12-bit build
        b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_valid  = 1'b1;
            b_in_opcode = tbl_b[i].opc;
            b_in_imm    = tbl_b[i].imm[11:0];
            tick();
            b_in_valid = 1'b0;
            check($sformatf("b_vec%0d_valid", i), 64'(b_out_valid), 64'd1);
            check($sformatf("b_vec%0d_imm", i), b_out_imm, tbl_b[i].exp_imm);
            check($sformatf("b_vec%0d_mode", i), 64'(b_out_mode), 64'(tbl_b[i].exp_mode));
        end
        tick();
        check("b_table_drain", 64'(b_out_valid), 64'd0);

        // backpressure: A, B fill the buffer, C waits, then all three drain in order
        a_out_ready = 1'b0;
        push_a(6'h08, 16'h0001);
        tick();
        check("bp_ready_after_a", 64'(a_in_ready), 64'd1);
        check("bp_head_a", 64'(a_out_imm), 64'h1);
        push_a(6'h04, 16'h0002);
        tick();
        check("bp_ready_after_b", 64'(a_in_ready), 64'd0);
        check("bp_head_still_a", 64'(a_out_imm), 64'h1);
        push_a(6'h03, 16'h0003);
        tick();
        tick();
        check("bp_c_held_ready", 64'(a_in_ready), 64'd0);
        check("bp_c_held_head", 64'(a_out_imm), 64'h1);
        check("bp_c_held_mode", 64'(a_out_mode), 64'd0);
        a_out_ready = 1'b1;
        tick();
        check("bp_out_b", 64'(a_out_imm), 64'h2);
        check("bp_out_b_mode", 64'(a_out_mode), 64'd2);
        check("bp_ready_reopen", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        check("bp_out_c", 64'(a_out_imm), 64'h00030000);
        check("bp_out_c_mode", 64'(a_out_mode), 64'd3);
        tick();
        check("bp_drained", 64'(a_out_valid), 64'd0);

        // streaming: one accept and one output per cycle
        a_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_a(6'h04, 16'(i + 16'h0100));
            check($sformatf("stream%0d_in_ready", i), 64'(a_in_ready), 64'd1);
            tick();
            check($sformatf("stream%0d_out", i), {31'd0, a_out_valid, a_out_imm},
                  {31'd0, 1'b1, 32'(i + 16'h0100)});
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drained", 64'(a_out_valid), 64'd0);

        // reset with two entries buffered and a push pending
        a_out_ready = 1'b0;
        push_a(6'h04, 16'h0055);
        tick();
        push_a(6'h04, 16'h0066);
        tick();
        check("mid_full", 64'(a_in_ready), 64'd0);
        push_a(6'h04, 16'h0077);
        a_out_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        check("mid_rst_out_imm", 64'(a_out_imm), 64'd0);
        check("mid_rst_out_mode", 64'(a_out_mode), 64'd0);
        rst = 1'b0;
        push_a(6'h04, 16'h0099);
        tick();
        a_in_valid = 1'b0;
        check("post_rst_first", {31'd0, a_out_valid, a_out_imm}, {31'd0, 1'b1, 32'h99});
        tick();
        check("post_rst_no_stale", 64'(a_out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
